// File: rtl/brick_pkg.sv
// Shared constants, cell codes and FSM encoding for the brick playfield.
package brick_pkg;

    localparam int COLS      = 20;
    localparam int ROWS      = 24;
    localparam int CELL_W    = 3;
    localparam int TILE_W    = 32;
    localparam int TILE_H    = 20;
    localparam int NUM_CELLS = COLS * ROWS;

    localparam logic [CELL_W-1:0] CELL_EMPTY  = 3'd0;
    localparam logic [CELL_W-1:0] CELL_WEAK   = 3'd1;
    localparam logic [CELL_W-1:0] CELL_STRONG = 3'd3;
    localparam logic [CELL_W-1:0] CELL_WALL   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INIT    = 2'd1,
        ST_LOOK    = 2'd2,
        ST_RESOLVE = 2'd3
    } state_e;

    // Code a cell becomes after one hit; anything unknown behaves as a wall.
    function automatic logic [CELL_W-1:0] degrade(input logic [CELL_W-1:0] code);
        logic [CELL_W-1:0] r;
        r = code;
        if (code == CELL_WEAK)   r = CELL_EMPTY;
        if (code == CELL_STRONG) r = CELL_WEAK;
        return r;
    endfunction

    // Cells that count toward clearing the level.
    function automatic logic is_destructible(input logic [CELL_W-1:0] code);
        return (code == CELL_WEAK) || (code == CELL_STRONG);
    endfunction

endpackage

// File: rtl/level_pattern_rom.sv
// Combinational level layout: (level, row, col) -> initial cell code.
module level_pattern_rom
    import brick_pkg::*;
(
    input  logic [1:0]        level,
    input  logic [4:0]        row,
    input  logic [4:0]        col,
    output logic [CELL_W-1:0] code
);

    // Rows not covered by a level's band stay empty.
    always_comb begin
        code = CELL_EMPTY;
        case (level)
            2'd0: begin
                if (row >= 5'd2 && row <= 5'd7) code = CELL_WEAK;
            end
            2'd1: begin
                if (row >= 5'd2 && row <= 5'd3)      code = CELL_STRONG;
                else if (row >= 5'd4 && row <= 5'd7) code = CELL_WEAK;
            end
            2'd2: begin
                if (row == 5'd2)                     code = col[0] ? CELL_EMPTY : CELL_WALL;
                else if (row >= 5'd3 && row <= 5'd8) code = col[0] ? CELL_WEAK : CELL_STRONG;
            end
            default: begin
                if (row >= 5'd2 && row <= 5'd9 && (row[0] == col[0])) code = CELL_WEAK;
            end
        endcase
    end

endmodule

// File: rtl/brick_field_writer.sv
// Owner and sole writer of the brick playfield: loads level patterns and
// resolves ball hits through a req/ack handshake.
module brick_field_writer #(
    parameter int COLS   = brick_pkg::COLS,
    parameter int ROWS   = brick_pkg::ROWS,
    parameter int CELL_W = brick_pkg::CELL_W,
    parameter int H_PIX  = 640,
    parameter int V_PIX  = 480
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   level_sel,
    input  logic                         hit_req,
    input  logic [9:0]                   hit_x,
    input  logic [9:0]                   hit_y,
    output logic                         hit_ack,
    output logic [CELL_W-1:0]            hit_code,
    output logic                         busy,
    output logic [COLS*ROWS*CELL_W-1:0]  bricks,
    output logic [8:0]                   bricks_left,
    output logic                         cleared
);
    import brick_pkg::*;

    localparam int NCELL = COLS * ROWS;
    localparam int IDX_W = $clog2(NCELL);

    state_e                         state_q, state_d;
    logic [1:0]                     level_q, level_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [5:0]                     row_q, row_d;
    logic [4:0]                     col_q, col_d;
    logic [9:0]                     hx_q, hx_d;
    logic [9:0]                     hy_q, hy_d;
    logic                           oob_q, oob_d;
    logic [NCELL-1:0][CELL_W-1:0]   cells_q, cells_d;
    logic [8:0]                     left_q, left_d;
    logic                           loaded_q, loaded_d;
    logic                           ack_q, ack_d;
    logic [CELL_W-1:0]              code_q, code_d;
    logic                           busy_q, busy_d;

    logic [CELL_W-1:0]              rom_code;
    logic [CELL_W-1:0]              old_code;
    logic [5:0]                     look_row;
    logic [4:0]                     look_col;
    logic [10:0]                    look_idx;

    level_pattern_rom u_rom (
        .level (level_q),
        .row   (row_q[4:0]),
        .col   (col_q),
        .code  (rom_code)
    );

    // Hit address decode: tile width is a power of two, tile height is not.
    always_comb begin
        look_col = hx_q[9:5];
        look_row = 6'(hy_q / 10'(TILE_H));
        look_idx = 11'(look_col) + 11'(look_row) * 11'(COLS);
    end

    // Out-of-field hits never touch the array, so the index is don't-care then.
    always_comb begin
        old_code = oob_q ? CELL_EMPTY : cells_q[idx_q];
    end

    // Next-state and datapath for the load / hit sequencer.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        idx_d    = idx_q;
        row_d    = row_q;
        col_d    = col_q;
        hx_d     = hx_q;
        hy_d     = hy_q;
        oob_d    = oob_q;
        cells_d  = cells_q;
        left_d   = left_q;
        loaded_d = loaded_q;
        ack_d    = 1'b0;
        code_d   = code_q;

        if (start && (state_q == ST_IDLE || state_q == ST_INIT)) begin
            // A (re)load drops loaded so cleared cannot flash while the count rebuilds.
            state_d  = ST_INIT;
            level_d  = level_sel;
            idx_d    = '0;
            row_d    = '0;
            col_d    = '0;
            left_d   = '0;
            loaded_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit_req) begin
                        hx_d    = hit_x;
                        hy_d    = hit_y;
                        state_d = ST_LOOK;
                    end
                end
                ST_INIT: begin
                    cells_d[idx_q] = rom_code;
                    if (is_destructible(rom_code)) left_d = left_q + 9'd1;
                    if (idx_q == IDX_W'(NCELL - 1)) begin
                        loaded_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (col_q == 5'(COLS - 1)) begin
                            col_d = '0;
                            row_d = row_q + 6'd1;
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end
                end
                ST_LOOK: begin
                    col_d   = look_col;
                    row_d   = look_row;
                    idx_d   = look_idx[IDX_W-1:0];
                    oob_d   = (hx_q >= 10'(H_PIX)) || (hy_q >= 10'(V_PIX));
                    state_d = ST_RESOLVE;
                end
                ST_RESOLVE: begin
                    code_d = old_code;
                    ack_d  = 1'b1;
                    if (!oob_q) begin
                        cells_d[idx_q] = degrade(old_code);
                        if (old_code == CELL_WEAK && left_q != 9'd0) left_d = left_q - 9'd1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            idx_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            hx_q     <= '0;
            hy_q     <= '0;
            oob_q    <= 1'b0;
            cells_q  <= '0;
            left_q   <= '0;
            loaded_q <= 1'b0;
            ack_q    <= 1'b0;
            code_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            row_q    <= row_d;
            col_q    <= col_d;
            hx_q     <= hx_d;
            hy_q     <= hy_d;
            oob_q    <= oob_d;
            cells_q  <= cells_d;
            left_q   <= left_d;
            loaded_q <= loaded_d;
            ack_q    <= ack_d;
            code_q   <= code_d;
            busy_q   <= busy_d;
        end
    end

    assign bricks      = cells_q;
    assign bricks_left = left_q;
    assign hit_ack     = ack_q;
    assign hit_code    = code_q;
    assign busy        = busy_q;
    assign cleared     = loaded_q && (left_q == 9'd0);

endmodule

// File: tb/tb_brick_field_writer.sv
// Directed bench for brick_field_writer.
module tb_brick_field_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   level_sel;
    logic         hit_req;
    logic [9:0]   hit_x;
    logic [9:0]   hit_y;
    logic         hit_ack;
    logic [2:0]   hit_code;
    logic         busy;
    logic [1439:0] bricks;
    logic [8:0]   bricks_left;
    logic         cleared;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    brick_field_writer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .level_sel   (level_sel),
        .hit_req     (hit_req),
        .hit_x       (hit_x),
        .hit_y       (hit_y),
        .hit_ack     (hit_ack),
        .hit_code    (hit_code),
        .busy        (busy),
        .bricks      (bricks),
        .bricks_left (bricks_left),
        .cleared     (cleared)
    );

    // Hand-written level table used to build expected fields.
    function automatic logic [2:0] exp_cell(input int lvl, input int r, input int c);
        logic [2:0] v;
        v = 3'd0;
        if (lvl == 0 && r >= 2 && r <= 7) v = 3'd1;
        if (lvl == 1 && r >= 2 && r <= 3) v = 3'd3;
        if (lvl == 1 && r >= 4 && r <= 7) v = 3'd1;
        if (lvl == 2 && r == 2 && (c % 2) == 0) v = 3'd5;
        if (lvl == 2 && r >= 3 && r <= 8) v = ((c % 2) == 0) ? 3'd3 : 3'd1;
        if (lvl == 3 && r >= 2 && r <= 9 && ((r + c) % 2) == 0) v = 3'd1;
        return v;
    endfunction

    function automatic logic [1439:0] exp_field(input int lvl);
        logic [1439:0] f;
        f = '0;
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 20; c++)
                f[3*(c + 20*r) +: 3] = exp_cell(lvl, r, c);
        return f;
    endfunction

    function automatic int diff_cells(input logic [1439:0] a, input logic [1439:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 480; i++)
            if (a[3*i +: 3] !== b[3*i +: 3]) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] lvl, output int cyc);
        step();
        start = 1'b1;
        level_sel = lvl;
        step();
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 600) begin
            cyc++;
            step();
        end
    endtask

    task automatic do_hit(input int x, input int y, output logic [2:0] code, output int lat);
        step();
        hit_req = 1'b1;
        hit_x = 10'(x);
        hit_y = 10'(y);
        step();
        hit_req = 1'b0;
        lat = 1;
        while (hit_ack !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        code = hit_code;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bricks !== '0) begin errors++; $display("FAIL reset_bricks: %0d cells nonzero", diff_cells(bricks, '0)); end
        checks++; if (bricks_left !== 9'd0) begin errors++; $display("FAIL reset_left: got %0d want 0", bricks_left); end
        checks++; if (hit_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", hit_ack); end
        checks++; if (hit_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", hit_code); end
        checks++; if (cleared !== 1'b0) begin errors++; $display("FAIL reset_cleared: got %b want 0", cleared); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_l0_load();
        int cyc;
        step();
        start = 1'b1;
        level_sel = 2'd0;
        step();
        start = 1'b0;
        repeat (50) step();
        rst = 1'b1;
        #1;
        checks++; if (bricks_left !== 9'd0 || busy !== 1'b0) begin errors++; $display("FAIL midload_reset: left %0d busy %b want 0 0", bricks_left, busy); end
        step();
        rst = 1'b0;
        do_load(2'd0, cyc);
        checks++; if (cyc !== 480) begin errors++; $display("FAIL l0_busy_cycles: got %0d want 480", cyc); end
        checks++; if (bricks_left !== 9'd120) begin errors++; $display("FAIL l0_left: got %0d want 120", bricks_left); end
        checks++; if (bricks !== exp_field(0)) begin errors++; $display("FAIL l0_field: %0d cells differ", diff_cells(bricks, exp_field(0))); end
        checks++; if (cleared !== 1'b0) begin errors++; $display("FAIL l0_cleared: got %b want 0", cleared); end
    endtask

    task automatic test_l0_hit();
        logic [2:0] code;
        int lat;
        do_hit(40, 45, code, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL l0_hit_latency: got %0d want 3", lat); end
        checks++; if (code !== 3'd1) begin errors++; $display("FAIL l0_hit_code: got %0d want 1", code); end
        checks++; if (bricks[125:123] !== 3'd0) begin errors++; $display("FAIL l0_hit_cell41: got %0d want 0", bricks[125:123]); end
        checks++; if (bricks_left !== 9'd119) begin errors++; $display("FAIL l0_hit_left: got %0d want 119", bricks_left); end
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        step();
        hit_req = 1'b1;
        hit_x = 10'd0;
        hit_y = 10'd0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (hit_ack === 1'b1) acks++;
        end
        hit_req = 1'b0;
        repeat (3) step();
        checks++; if (acks !== 3) begin errors++; $display("FAIL held_req_acks: got %0d want 3", acks); end
        checks++; if (bricks_left !== 9'd119) begin errors++; $display("FAIL held_req_left: got %0d want 119", bricks_left); end
    endtask

    task automatic test_l1_hits();
        logic [2:0] code;
        int lat, cyc;
        do_load(2'd1, cyc);
        checks++; if (bricks_left !== 9'd120) begin errors++; $display("FAIL l1_left: got %0d want 120", bricks_left); end
        do_hit(0, 40, code, lat);
        checks++; if (code !== 3'd3) begin errors++; $display("FAIL l1_hit1_code: got %0d want 3", code); end
        checks++; if (bricks[122:120] !== 3'd1) begin errors++; $display("FAIL l1_hit1_cell: got %0d want 1", bricks[122:120]); end
        checks++; if (bricks_left !== 9'd120) begin errors++; $display("FAIL l1_hit1_left: got %0d want 120", bricks_left); end
        do_hit(0, 40, code, lat);
        checks++; if (code !== 3'd1) begin errors++; $display("FAIL l1_hit2_code: got %0d want 1", code); end
        checks++; if (bricks[122:120] !== 3'd0) begin errors++; $display("FAIL l1_hit2_cell: got %0d want 0", bricks[122:120]); end
        checks++; if (bricks_left !== 9'd119) begin errors++; $display("FAIL l1_hit2_left: got %0d want 119", bricks_left); end
    endtask

    task automatic test_l2_wall_oob();
        logic [2:0] code;
        int lat, cyc;
        do_load(2'd2, cyc);
        do_hit(640, 10, code, lat);
        checks++; if (lat !== 3 || code !== 3'd0) begin errors++; $display("FAIL oob_x640: lat %0d code %0d want 3 0", lat, code); end
        do_hit(700, 40, code, lat);
        checks++; if (lat !== 3 || code !== 3'd0) begin errors++; $display("FAIL oob_x700: lat %0d code %0d want 3 0", lat, code); end
        do_hit(0, 480, code, lat);
        checks++; if (lat !== 3 || code !== 3'd0) begin errors++; $display("FAIL oob_y480: lat %0d code %0d want 3 0", lat, code); end
        do_hit(0, 40, code, lat);
        checks++; if (code !== 3'd5) begin errors++; $display("FAIL wall_code: got %0d want 5", code); end
        checks++; if (bricks !== exp_field(2)) begin errors++; $display("FAIL l2_field_unchanged: %0d cells differ", diff_cells(bricks, exp_field(2))); end
        checks++; if (bricks_left !== 9'd120) begin errors++; $display("FAIL l2_left: got %0d want 120", bricks_left); end
    endtask

    task automatic test_start_priority_and_reset();
        int acks, lows;
        acks = 0;
        lows = 0;
        step();
        start = 1'b1;
        level_sel = 2'd0;
        hit_req = 1'b1;
        hit_x = 10'd40;
        hit_y = 10'd45;
        step();
        start = 1'b0;
        hit_req = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (hit_ack === 1'b1) acks++;
            if (busy !== 1'b1) lows++;
            step();
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL start_prio_ack: got %0d acks want 0", acks); end
        checks++; if (lows !== 0) begin errors++; $display("FAIL start_prio_busy: %0d idle cycles want 0", lows); end
        checks++; if (bricks_left !== 9'd120) begin errors++; $display("FAIL init200_left: got %0d want 120", bricks_left); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || hit_ack !== 1'b0 || hit_code !== 3'd0) begin errors++; $display("FAIL rst_mid_ctrl: busy %b ack %b code %0d want 0 0 0", busy, hit_ack, hit_code); end
        checks++; if (bricks !== '0 || bricks_left !== 9'd0 || cleared !== 1'b0) begin errors++; $display("FAIL rst_mid_field: %0d cells nonzero left %0d cleared %b", diff_cells(bricks, '0), bricks_left, cleared); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_l3_clear();
        logic [2:0] code;
        int lat, cyc, bad, n;
        bad = 0;
        n = 0;
        do_load(2'd3, cyc);
        checks++; if (bricks_left !== 9'd80) begin errors++; $display("FAIL l3_left: got %0d want 80", bricks_left); end
        for (int r = 2; r <= 9; r++) begin
            for (int c = 0; c < 20; c++) begin
                if (((r + c) % 2) == 0) begin
                    do_hit(c*32 + 7, r*20 + 11, code, lat);
                    n++;
                    if (code !== 3'd1 || lat !== 3) bad++;
                    if (n == 79) begin
                        checks++; if (cleared !== 1'b0 || bricks_left !== 9'd1) begin errors++; $display("FAIL l3_before_last: cleared %b left %0d want 0 1", cleared, bricks_left); end
                    end
                end
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL l3_hit_codes: %0d bad hits want 0", bad); end
        checks++; if (bricks_left !== 9'd0 || cleared !== 1'b1) begin errors++; $display("FAIL l3_cleared: left %0d cleared %b want 0 1", bricks_left, cleared); end
        do_hit(32, 40, code, lat);
        checks++; if (code !== 3'd0 || bricks_left !== 9'd0 || cleared !== 1'b1) begin errors++; $display("FAIL l3_no_underflow: code %0d left %0d cleared %b", code, bricks_left, cleared); end
    endtask

    initial begin
        start = 1'b0;
        level_sel = 2'd0;
        hit_req = 1'b0;
        hit_x = 10'd0;
        hit_y = 10'd0;
        test_reset();
        test_l0_load();
        test_l0_hit();
        test_back_to_back();
        test_l1_hits();
        test_l2_wall_oob();
        test_start_priority_and_reset();
        test_l3_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
